uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
Serial receive front end for the TinyQV UART peripheral. It sits directly upstream of the peripheral's instruction-memory write path. It oversamples the ui_in[7] RX line and deserialises 8N1 frames, LSB first. It presents each byte on dout with a level rdy flag, which the consumer acknowledges with a one-cycle rdy_clr pulse. Framing and overrun errors are flagged alongside the data.

Parameters:
CLK_HZ, 64000000, project clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; must be at least 8 and even
DIV (localparam), round(CLK_HZ/(BAUD*OVERSAMPLE)), clocks per tick; 35 at default values; minimum 1

Ports:
clk  in  1  project clock; the only clock
rst  in  1  synchronous, active-high reset
rx  in  1  raw serial line; asynchronous; idles high
rdy_clr  in  1  one-cycle pulse; consumer has taken dout
dout  out  8  last good received byte
rdy  out  1  dout holds an unconsumed byte
frame_err  out  1  sticky; a stop bit was sampled low
overrun  out  1  sticky; a byte completed while rdy=1
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all of the following apply on a synchronous rst at a clk edge.
  - Outputs: dout=0, rdy=0, frame_err=0, overrun=0, busy=0.
  - State returns to IDLE.
  - Both synchroniser flops are set to 1, so the line reads as idle.
  - Tick divider and all counters clear.
  - A rst in the middle of a frame abandons the frame. No partial byte becomes visible.
- Input sync: rx passes through 2 flops to give rxs. This adds 2 cycles of latency. Only rxs is used internally.
- Tick: the divider counts 0..DIV-1 and emits a 1-cycle tick on wrap. It is forced to 0 on entry to START so that bit phase aligns to the detected edge. With DIV=1, tick is high on every cycle.
- Bit timing and sampling:
  - tcnt counts ticks 0..OVERSAMPLE-1 within each bit.
  - rxs is sampled at ticks M-1, M and M+1, where M=OVERSAMPLE/2.
  - The bit value is the 2-of-3 majority, decided at tick M+1.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rxs==0 moves to START. tcnt=0 on entry.
  - START: at decision, a majority of 0 moves to DATA with bcnt=0. A majority of 1 is a glitch: return to IDLE with no flags changed. The remainder of the start bit runs until tcnt wraps.
  - DATA: at each decision, shift the bit in at shreg[7] (right shift). At tcnt wrap, bcnt increments. After bcnt=7 wraps, move to STOP.
  - STOP, decision majority 1 (good frame):
    - rdy=0, or rdy_clr in the same cycle: dout<=shreg and rdy<=1 on the next edge.
    - rdy=1 and no rdy_clr: overrun<=1. The new byte is dropped and dout keeps the old byte.
    - Then return to IDLE immediately, which leaves half a bit of slack for re-sync.
  - STOP, decision majority 0: frame_err<=1, the byte is discarded and rdy is unchanged. Move to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1, then move to IDLE. A held break therefore produces one error, not a stream of 0x00 bytes.
- Handshake:
  - rdy_clr clears rdy, frame_err and overrun on the next edge.
  - If rdy_clr coincides with a good-frame load, the load wins: rdy stays 1 with the new byte and no overrun is raised.
  - rdy_clr while rdy=0 has no effect beyond clearing the flags.
- Latency: rdy rises 2 + DIV*(9*OVERSAMPLE + M + 1) + 1 cycles after the rx falling edge, within ±DIV cycles of divider phase.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - the function computing DIV;
  - the constants DATA_BITS=8 and IDLE_LEVEL=1'b1.
- Sub-module uart_baud_tick holds the divider, with inputs clk, rst and restart, and output tick. The TX side reuses it.

Test Plan:
All tests use CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16 (DIV=1, 16 clocks per bit).
1. Send 0xA5, then pulse rdy_clr -> dout=0xA5 and rdy=1 at cycle 2+153+1 from the edge; frame_err=0 and overrun=0; rdy=0 one cycle after rdy_clr.
2. Send 0x3C then 0xC3 back to back with no rdy_clr -> dout=0x3C, rdy=1, overrun=1; the following rdy_clr clears both flags.
3. Send 0x55 with the stop bit forced low, held low for 3 more bit times -> frame_err=1, rdy=0, exactly one error, back in IDLE after the line rises; a following 0x81 is received correctly.
4. A 4-cycle low glitch on idle rx -> returns to IDLE with no rdy or flags; a 1-cycle low spike inside a data bit at tick M -> majority voting preserves the sent byte 0xFF.
5. Assert rst at bit 4 of a 0x12 frame, then send 0x34 -> no byte after reset; dout=0x34, rdy=1.
6. rdy_clr in the exact cycle a 0x99 frame completes while rdy=1 -> dout=0x99, rdy=1, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame constants
// and the baud divider calculation used by the RX and TX sides.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_e;

   localparam int unsigned DATA_BITS  = 8;
   localparam logic        IDLE_LEVEL = 1'b1;

   // Clocks per oversample tick, rounded to nearest, never below 1.
   function automatic int unsigned calc_div(
      input int unsigned clk_hz,
      input int unsigned baud,
      input int unsigned os
   );
      int unsigned per;
      int unsigned d;
      per = baud * os;
      d   = (clk_hz + per / 2) / per;
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks,
// phase realigned by restart.
module uart_baud_tick #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserialiser with 3-sample majority voting,
// level rdy handshake and sticky framing/overrun flags.
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 64000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rdy_clr,
   output logic [7:0] dout,
   output logic       rdy,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int unsigned M   = OVERSAMPLE / 2;
   localparam int unsigned TW  = $clog2(OVERSAMPLE);
   localparam int unsigned BW  = $clog2(DATA_BITS);

   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_LO   = TW'(M - 1);
   localparam logic [TW-1:0] T_MID  = TW'(M);
   localparam logic [TW-1:0] T_HI   = TW'(M + 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   rx_state_e state_q, state_d;

   logic                 s1_q, rxs_q;
   logic [TW-1:0]        tcnt_q, tcnt_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [1:0]           smp_q, smp_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [7:0]           dout_q, dout_d;
   logic                 rdy_q, rdy_d;
   logic                 fe_q, fe_d;
   logic                 ov_q, ov_d;

   logic tick;
   logic restart;
   logic wrap;
   logic dec;
   logic maj;

   assign restart = (state_q == IDLE) && (rxs_q != IDLE_LEVEL);
   assign wrap    = tick && (tcnt_q == T_LAST);
   assign dec     = tick && (tcnt_q == T_HI);
   assign maj     = (smp_q[0] & smp_q[1]) |
                    (smp_q[0] & rxs_q) |
                    (smp_q[1] & rxs_q);

   uart_baud_tick #(
      .DIV(DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .tick   (tick)
   );

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bcnt_d  = bcnt_q;
      smp_d   = smp_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      rdy_d   = rdy_q;
      fe_d    = fe_q;
      ov_d    = ov_q;

      if (rdy_clr) begin
         rdy_d = 1'b0;
         fe_d  = 1'b0;
         ov_d  = 1'b0;
      end

      if (tick) begin
         tcnt_d = wrap ? '0 : tcnt_q + 1'b1;
         if (tcnt_q == T_LO) smp_d[0] = rxs_q;
         if (tcnt_q == T_MID) smp_d[1] = rxs_q;
      end

      unique case (state_q)
         IDLE: begin
            tcnt_d = '0;
            bcnt_d = '0;
            if (rxs_q != IDLE_LEVEL) state_d = START;
         end
         START: begin
            if (dec && maj) begin
               state_d = IDLE;
            end else if (wrap) begin
               state_d = DATA;
               bcnt_d  = '0;
            end
         end
         DATA: begin
            if (dec) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
            if (wrap) begin
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == B_LAST) begin
                  state_d = STOP;
                  bcnt_d  = '0;
               end
            end
         end
         STOP: begin
            if (dec) begin
               if (maj) begin
                  // A load coinciding with rdy_clr wins over the clear.
                  if (!rdy_q || rdy_clr) begin
                     dout_d = shreg_q;
                     rdy_d  = 1'b1;
                  end else begin
                     ov_d = 1'b1;
                  end
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rxs_q == IDLE_LEVEL) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= IDLE_LEVEL;
         rxs_q   <= IDLE_LEVEL;
         state_q <= IDLE;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         smp_q   <= '0;
         shreg_q <= '0;
         dout_q  <= '0;
         rdy_q   <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         s1_q    <= rx;
         rxs_q   <= s1_q;
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         smp_q   <= smp_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         rdy_q   <= rdy_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   assign dout      = dout_q;
   assign rdy       = rdy_q;
   assign frame_err = fe_q;
   assign overrun   = ov_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 16 clocks per bit,
// with an expected-byte queue checked against dout.
module tb_uart_rx_deser;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rdy_clr;
   logic [7:0] dout;
   logic       rdy;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_cyc = -1;
   int fe_rises = 0;
   int cstart = 0;
   int fe_base;
   logic rdy_p = 1'b0;
   logic fe_p = 1'b0;
   logic [7:0] exp_q[$];

   uart_rx_deser #(
      .CLK_HZ    (1600000),
      .BAUD      (100000),
      .OVERSAMPLE(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .rdy_clr  (rdy_clr),
      .dout     (dout),
      .rdy      (rdy),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rdy && !rdy_p) rise_cyc = cyc;
      if (frame_err && !fe_p) fe_rises++;
      rdy_p = rdy;
      fe_p  = frame_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_byte(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: got %0h expected none (queue empty)", tag, dout);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {24'd0, dout}, {24'd0, e});
      end
   endtask

   // Drive one frame on negedges; index i is the bit-time slot.
   task automatic send(input logic [7:0] b, input logic stop_lvl,
                       input int spike_i, input int clr_i,
                       input int abort_i);
      logic [9:0] fr;
      logic v;
      fr = {stop_lvl, b, 1'b0};
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         if (i == abort_i) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            rx  = 1'b1;
            return;
         end
         v = fr[i / 16];
         if (i == spike_i) v = ~v;
         rx      = v;
         rdy_clr = (i == clr_i);
         if (i == 0) cstart = cyc + 1;
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      rdy_clr = 1'b1;
      @(negedge clk);
      rdy_clr = 1'b0;
   endtask

   initial begin
      int lat;
      rst     = 1'b1;
      rx      = 1'b1;
      rdy_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dout", {24'd0, dout}, 32'h0);
      chk("rst_rdy", {31'd0, rdy}, 32'd0);
      chk("rst_fe", {31'd0, frame_err}, 32'd0);
      chk("rst_ov", {31'd0, overrun}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // single byte, latency and clear
      rise_cyc = -1;
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1, -1, -1, -1);
      lat = rise_cyc - cstart;
      checks++;
      assert (lat >= 155 && lat <= 157) else begin
         errors++;
         $error("FAIL t1_latency: got %0d expected 156+-1", lat);
      end
      chk_byte("t1_dout");
      chk("t1_rdy", {31'd0, rdy}, 32'd1);
      chk("t1_fe", {31'd0, frame_err}, 32'd0);
      chk("t1_ov", {31'd0, overrun}, 32'd0);
      pulse_clr();
      chk("t1_rdy_clr", {31'd0, rdy}, 32'd0);

      // back to back without clear -> overrun
      exp_q.push_back(8'h3C);
      send(8'h3C, 1'b1, -1, -1, -1);
      send(8'hC3, 1'b1, -1, -1, -1);
      chk_byte("t2_dout");
      chk("t2_rdy", {31'd0, rdy}, 32'd1);
      chk("t2_ov", {31'd0, overrun}, 32'd1);
      pulse_clr();
      chk("t2_rdy_clr", {31'd0, rdy}, 32'd0);
      chk("t2_ov_clr", {31'd0, overrun}, 32'd0);

      // framing error with held break
      fe_base = fe_rises;
      send(8'h55, 1'b0, -1, -1, -1);
      repeat (48) begin
         @(negedge clk);
         rx = 1'b0;
      end
      chk("t3_fe", {31'd0, frame_err}, 32'd1);
      chk("t3_rdy", {31'd0, rdy}, 32'd0);
      chk("t3_busy_wait", {31'd0, busy}, 32'd1);
      chk("t3_one_err", fe_rises - fe_base, 32'd1);
      @(negedge clk);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      chk("t3_idle", {31'd0, busy}, 32'd0);
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1, -1, -1, -1);
      chk_byte("t3_dout");
      chk("t3_rdy2", {31'd0, rdy}, 32'd1);
      pulse_clr();
      chk("t3_fe_clr", {31'd0, frame_err}, 32'd0);

      // short glitch on idle line
      repeat (4) begin
         @(negedge clk);
         rx = 1'b0;
      end
      @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("t4_glitch_busy", {31'd0, busy}, 32'd0);
      chk("t4_glitch_rdy", {31'd0, rdy}, 32'd0);
      chk("t4_glitch_fe", {31'd0, frame_err}, 32'd0);
      chk("t4_glitch_ov", {31'd0, overrun}, 32'd0);

      // spike on centre sample of bit 3
      exp_q.push_back(8'hFF);
      send(8'hFF, 1'b1, 73, -1, -1);
      chk_byte("t4_spike_dout");
      chk("t4_spike_rdy", {31'd0, rdy}, 32'd1);

      // reset in mid frame
      send(8'h12, 1'b1, -1, -1, 88);
      repeat (20) @(negedge clk);
      chk("t5_rdy", {31'd0, rdy}, 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_dout", {24'd0, dout}, 32'h0);
      exp_q.push_back(8'h34);
      send(8'h34, 1'b1, -1, -1, -1);
      chk_byte("t5_dout2");
      chk("t5_rdy2", {31'd0, rdy}, 32'd1);

      // clear coincident with load while rdy=1
      exp_q.push_back(8'h99);
      send(8'h99, 1'b1, -1, 156, -1);
      chk_byte("t6_dout");
      chk("t6_rdy", {31'd0, rdy}, 32'd1);
      chk("t6_ov", {31'd0, overrun}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
